// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single memory-controller command port between the camera writer and LCD reader.
// One fixed-length burst per grant, a command gap after every burst, and a sticky read timeout.
module sdram_port_arbiter #(
    parameter int unsigned BURST_WORDS = 8,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned RD_TIMEOUT  = 64,
    parameter int unsigned MAX_RD_RUN  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_done,
    input  logic        wr_req,
    input  logic [20:0] wr_addr,
    input  logic [31:0] wr_data_in,
    output logic        wr_word_ack,
    output logic        wr_gnt,
    input  logic        rd_req,
    input  logic [20:0] rd_addr,
    output logic        rd_gnt,
    output logic [31:0] rd_data_out,
    output logic        rd_valid_out,
    output logic        rd_done,
    output logic        cmd,
    output logic        cmd_en,
    output logic [20:0] addr,
    output logic [31:0] wr_data,
    output logic [3:0]  data_mask,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    output logic        error
);

    localparam int unsigned TMAX = (RD_TIMEOUT > GAP_CYCLES) ? RD_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(BURST_WORDS + 1);
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = $clog2(MAX_RD_RUN + 1);

    localparam logic [CW-1:0] WORD_LAST = CW'(BURST_WORDS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RD_RUN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_GAP,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          cmd_en_q, cmd_en_d;
    logic          cmd_q, cmd_d;
    logic          rd_gnt_q, rd_gnt_d;
    logic          wr_gnt_q, wr_gnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_done_q, rd_done_d;
    logic          error_q, error_d;
    logic [20:0]   addr_q, addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   rd_data_q, rd_data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            run_q      <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            cmd_en_q   <= 1'b0;
            cmd_q      <= 1'b0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            cmd_en_q   <= cmd_en_d;
            cmd_q      <= cmd_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_done_q  <= rd_done_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        cmd_en_d   = 1'b0;
        cmd_d      = cmd_q;
        rd_gnt_d   = 1'b0;
        wr_gnt_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        error_d    = error_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            S_IDLE: begin
                // Reads win unless the run limit is hit while a write is waiting.
                if (init_done && !error_q) begin
                    if (rd_req && ((run_q < RUN_MAX) || !wr_req)) begin
                        state_d = S_RD_CMD;
                    end else if (wr_req) begin
                        state_d = S_WR_BURST;
                        cnt_d   = '0;
                    end
                end
            end
            S_RD_CMD: begin
                rd_gnt_d = 1'b1;
                cmd_en_d = 1'b1;
                cmd_d    = 1'b0;
                addr_d   = rd_addr;
                run_d    = wr_req ? run_q + 1'b1 : '0;
                cnt_d    = '0;
                tmr_d    = '0;
                state_d  = S_RD_WAIT;
            end
            S_RD_WAIT, S_RD_BURST: begin
                if (rd_data_valid) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_data;
                    if (cnt_q == WORD_LAST) begin
                        rd_done_d = 1'b1;
                        tmr_d     = '0;
                        state_d   = S_GAP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_RD_BURST;
                    end
                end else if (state_q == S_RD_WAIT) begin
                    // Timer only runs until the first word; later valid gaps are tolerated.
                    if (tmr_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_WR_BURST: begin
                wr_data_d = wr_data_in;
                if (cnt_q == '0) begin
                    cmd_en_d = 1'b1;
                    cmd_d    = 1'b1;
                    addr_d   = wr_addr;
                    wr_gnt_d = 1'b1;
                end
                if (cnt_q == WORD_LAST) begin
                    run_d   = '0;
                    tmr_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wr_word_ack  = (state_q == S_WR_BURST);
    assign wr_gnt       = wr_gnt_q;
    assign rd_gnt       = rd_gnt_q;
    assign rd_data_out  = rd_data_q;
    assign rd_valid_out = rd_valid_q;
    assign rd_done      = rd_done_q;
    assign cmd          = cmd_q;
    assign cmd_en       = cmd_en_q;
    assign addr         = addr_q;
    assign wr_data      = wr_data_q;
    assign data_mask    = 4'h0;
    assign error        = error_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: grant-sequence vector table, controller/source models feeding
// read/write scoreboards, and hand sequences for init gating, timeout, stray data and reset.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int unsigned BW   = 8;
    localparam int unsigned GAP  = 4;
    localparam int unsigned TMO  = 64;
    localparam int unsigned RUN  = 4;
    localparam int          NONE = 0;
    localparam int          RD   = 1;
    localparam int          WR   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_done = 1'b0;
    logic        wr_req = 1'b0;
    logic [20:0] wr_addr = '0;
    logic [31:0] wr_data_in;
    logic        wr_word_ack, wr_gnt;
    logic        rd_req = 1'b0;
    logic [20:0] rd_addr = '0;
    logic        rd_gnt;
    logic [31:0] rd_data_out;
    logic        rd_valid_out, rd_done, cmd, cmd_en;
    logic [20:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  data_mask;
    logic [31:0] rd_data;
    logic        rd_data_valid;
    logic        error;
    logic [96:0] outs;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .BURST_WORDS(BW),
        .GAP_CYCLES (GAP),
        .RD_TIMEOUT (TMO),
        .MAX_RD_RUN (RUN)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .init_done    (init_done),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data_in   (wr_data_in),
        .wr_word_ack  (wr_word_ack),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_data_out  (rd_data_out),
        .rd_valid_out (rd_valid_out),
        .rd_done      (rd_done),
        .cmd          (cmd),
        .cmd_en       (cmd_en),
        .addr         (addr),
        .wr_data      (wr_data),
        .data_mask    (data_mask),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .error        (error)
    );

    assign outs = {wr_word_ack, wr_gnt, rd_gnt, rd_data_out, rd_valid_out, rd_done,
                   cmd, cmd_en, addr, wr_data, data_mask, error};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    sb_t rd_q[$];
    sb_t wr_q[$];

    bit ctl_silent = 1'b0;
    int ctl_stray  = 0;
    int burst_no   = 0;
    int last_end   = 0;
    bit have_end   = 1'b0;
    int k          = 0;
    bit adv        = 1'b0;
    int ack_run    = 0;
    int rd_seen    = 0;
    int rd_out_cnt = 0;
    int cmd_cnt    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Controller model: 8 words after a 6-cycle delay, every other burst with one mid-burst hole.
    initial begin
        int dly;
        int left;
        bit hole;
        bit holed;
        dly = 0; left = 0; hole = 1'b0; holed = 1'b0;
        rd_data = '0;
        rd_data_valid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rd_data_valid = 1'b0;
            if (!reset_n) begin
                dly = 0;
                left = 0;
            end else if (cmd_en && !cmd && !ctl_silent) begin
                dly = 6;
                left = BW;
                hole = burst_no[0];
                holed = 1'b0;
                burst_no++;
            end else if (left > 0) begin
                if (dly > 0) begin
                    dly--;
                end else if (hole && !holed && left == 4) begin
                    holed = 1'b1;
                end else begin
                    rd_data = $urandom;
                    rd_data_valid = 1'b1;
                    rd_q.push_back('{rd_data, cyc});
                    left--;
                    if (left == 0) begin
                        last_end = cyc;
                        have_end = 1'b1;
                    end
                end
            end else if (ctl_stray > 0) begin
                rd_data = 32'hDEAD_0000;
                rd_data_valid = 1'b1;
                ctl_stray--;
            end
        end
    end

    // Write source: first-word-fall-through, word k = 0xA0+k, advances after each acked edge.
    initial begin
        wr_data_in = 32'hA0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                k = 0;
                adv = 1'b0;
            end else if (adv) begin
                k = (k + 1) % BW;
                adv = 1'b0;
            end
            wr_data_in = 32'hA0 + 32'(k);
        end
    end

    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rd_q.delete();
                wr_q.delete();
                ack_run = 0;
                rd_seen = 0;
                have_end = 1'b0;
            end else begin
                if (wr_q.size() > 0) begin
                    e = wr_q.pop_front();
                    chk("wr_data", wr_data, e.data);
                end
                if (wr_word_ack) begin
                    wr_q.push_back('{32'hA0 + 32'(k), cyc});
                    adv = 1'b1;
                    ack_run++;
                    if (ack_run == BW) begin
                        last_end = cyc;
                        have_end = 1'b1;
                    end
                end else if (ack_run > 0) begin
                    chk("wr_ack_run", ack_run, BW);
                    ack_run = 0;
                end
                if (rd_valid_out) begin
                    rd_out_cnt++;
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected", 1, 0);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_data", rd_data_out, e.data);
                        chk("rd_latency", cyc - e.cyc, 1);
                        chk("rd_done", rd_done, (rd_seen == BW - 1));
                        rd_seen = (rd_seen + 1) % BW;
                    end
                end else if (rd_done) begin
                    chk("rd_done_alone", 1, 0);
                end
                if (cmd_en || rd_gnt || wr_gnt) begin
                    chk("gnt_vs_cmd", {rd_gnt, wr_gnt}, cmd_en ? {~cmd, cmd} : 2'b00);
                end
                if (cmd_en) begin
                    cmd_cnt++;
                    chk("data_mask", data_mask, 0);
                    if (have_end) chk("cmd_gap_ok", (cyc - last_end) >= int'(GAP + 1), 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          init;
        bit          rd;
        bit          wr;
        int          budget;
        int          exp;
        logic [20:0] ra;
        logic [20:0] wa;
    } vec_t;

    task automatic wait_cmd(input int budget, output bit got);
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (cmd_en) got = 1'b1;
        end
    endtask

    initial begin
        vec_t tbl[15];
        bit   got;
        int   c0;
        int   n0;
        bit   seen;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 100, NONE, 21'h4B020, 21'h12340};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2,   RD,   21'h4B020, 21'h12340};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 40,  WR,   21'h4B020, 21'h12340};
        for (int i = 3; i <= 12; i++) begin
            tbl[i] = '{1'b1, 1'b1, 1'b1, 40, (((i - 3) % 5) == 4) ? WR : RD,
                       21'h4B020 + 21'(i * 32), 21'h12340 + 21'(i * 32)};
        end
        tbl[13] = '{1'b1, 1'b1, 1'b0, 40,  RD,   21'h1FFFE0, 21'h12340};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 40,  NONE, 21'h00000,  21'h00000};

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            init_done = tbl[i].init;
            rd_req    = tbl[i].rd;
            wr_req    = tbl[i].wr;
            rd_addr   = tbl[i].ra;
            wr_addr   = tbl[i].wa;
            wait_cmd(tbl[i].budget, got);
            if (tbl[i].exp == NONE) begin
                chk($sformatf("v%0d_no_cmd", i), got, 0);
            end else begin
                chk($sformatf("v%0d_cmd_seen", i), got, 1);
                chk($sformatf("v%0d_cmd_dir", i), cmd, (tbl[i].exp == WR));
                chk($sformatf("v%0d_addr", i), addr, (tbl[i].exp == WR) ? tbl[i].wa : tbl[i].ra);
            end
        end

        // Stray read data while idle must not reach the reader.
        n0 = rd_out_cnt;
        ctl_stray = 3;
        repeat (8) @(negedge clk);
        chk("stray_ignored", rd_out_cnt - n0, 0);

        // Read that never returns data.
        ctl_silent = 1'b1;
        rd_addr = 21'h00777;
        rd_req = 1'b1;
        wait_cmd(30, got);
        chk("tmo_cmd_seen", got, 1);
        chk("tmo_cmd_dir", cmd, 0);
        c0 = cyc;
        rd_req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (error) seen = 1'b1;
        end
        chk("tmo_cycles", cyc - c0, TMO);
        rd_req = 1'b1;
        wr_req = 1'b1;
        n0 = cmd_cnt;
        repeat (60) @(negedge clk);
        chk("no_cmd_in_error", cmd_cnt - n0, 0);
        chk("error_sticky", error, 1);
        #2 reset_n = 1'b0;
        #1 chk("reset_clears_error", outs, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_req = 1'b0;
        ctl_silent = 1'b0;

        // Write interrupted by reset during word 3, then a clean write.
        wr_addr = 21'h12340;
        wait_cmd(20, got);
        chk("wr1_cmd_seen", got, 1);
        chk("wr1_cmd_dir", cmd, 1);
        chk("wr1_addr", addr, 21'h12340);
        @(negedge clk);
        @(negedge clk);
        chk("wr1_word3_ack", {wr_word_ack, wr_data_in}, {1'b1, 32'hA3});
        #2 reset_n = 1'b0;
        #1 chk("reset_midburst", outs, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wr_addr = 21'h0ABCD;
        wait_cmd(20, got);
        chk("wr2_cmd_seen", got, 1);
        chk("wr2_cmd_dir", cmd, 1);
        chk("wr2_addr", addr, 21'h0ABCD);
        wr_req = 1'b0;
        repeat (20) @(negedge clk);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("final_error", error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
